// File: rtl/md_unit_control_if.sv
// E-stage MD instruction bus and HI/LO/stall outputs of the multiply/divide unit.
interface md_unit_control_if;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs_value;
    logic [31:0] E_rt_value;
    logic        D_md_use;
    logic        md_stall;
    logic        busy;
    logic [31:0] E_md_read_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output E_md_op, E_rs_value, E_rt_value, D_md_use,
        input  md_stall, busy, E_md_read_data, hi, lo
    );

    modport slave (
        input  E_md_op, E_rs_value, E_rt_value, D_md_use,
        output md_stall, busy, E_md_read_data, hi, lo
    );
endinterface

// File: rtl/md_unit_control.sv
// Multi-cycle multiply/divide controller owning HI/LO; results are computed at start and
// committed to HI/LO when the down-counter expires.
module md_unit_control #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic              clk,
    input logic              reset_n,
    md_unit_control_if.slave md_if
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_pend_hi;
    logic [31:0]       r_pend_lo;

    logic              w_is_start;
    logic              w_is_mult;
    logic [31:0]       w_rs;
    logic [31:0]       w_rt;
    logic [63:0]       w_prod_s;
    logic [63:0]       w_prod_u;
    logic [31:0]       w_q_s;
    logic [31:0]       w_r_s;
    logic [31:0]       w_q_u;
    logic [31:0]       w_r_u;
    logic [31:0]       w_res_hi;
    logic [31:0]       w_res_lo;

    assign w_rs = md_if.E_rs_value;
    assign w_rt = md_if.E_rt_value;

    always_comb begin
        w_is_start = (md_if.E_md_op >= OpMult) && (md_if.E_md_op <= OpDivu);
        w_is_mult  = (md_if.E_md_op == OpMult) || (md_if.E_md_op == OpMultu);

        w_prod_s = $signed({{32{w_rs[31]}}, w_rs}) * $signed({{32{w_rt[31]}}, w_rt});
        w_prod_u = {32'd0, w_rs} * {32'd0, w_rt};
        w_q_s    = $signed(w_rs) / $signed(w_rt);
        w_r_s    = $signed(w_rs) % $signed(w_rt);
        w_q_u    = w_rs / w_rt;
        w_r_u    = w_rs % w_rt;

        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        unique case (md_if.E_md_op)
            OpMult: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            OpMultu: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            OpDiv: begin
                if (w_rt == 32'd0) begin
                    w_res_hi = w_rs;
                    w_res_lo = 32'hFFFF_FFFF;
                end else if (w_rs == 32'h8000_0000 && w_rt == 32'hFFFF_FFFF) begin
                    // Quotient overflows 32 bits; pin to the MIPS-style wrapped result.
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_r_s;
                    w_res_lo = w_q_s;
                end
            end
            OpDivu: begin
                if (w_rt == 32'd0) begin
                    w_res_hi = w_rs;
                    w_res_lo = 32'hFFFF_FFFF;
                end else begin
                    w_res_hi = w_r_u;
                    w_res_lo = w_q_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_is_start) begin
                        r_pend_hi <= w_res_hi;
                        r_pend_lo <= w_res_lo;
                        r_cnt     <= w_is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                        r_state   <= StRun;
                    end else if (md_if.E_md_op == OpMthi) begin
                        r_hi <= w_rs;
                    end else if (md_if.E_md_op == OpMtlo) begin
                        r_lo <= w_rs;
                    end
                end
                StRun: begin
                    // Any E op arriving here is a protocol violation and is dropped.
                    if (r_cnt == CntW'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        md_if.busy     = (r_state == StRun);
        md_if.hi       = r_hi;
        md_if.lo       = r_lo;
        md_if.md_stall = md_if.D_md_use && ((r_state == StRun) || w_is_start);
        md_if.E_md_read_data = 32'd0;
        if (md_if.E_md_op == OpMfhi) begin
            md_if.E_md_read_data = r_hi;
        end else if (md_if.E_md_op == OpMflo) begin
            md_if.E_md_read_data = r_lo;
        end
    end
endmodule

// File: doc/md_unit_control.md
# md_unit_control

Multiply/divide unit controller for the five-stage pipeline. It accepts MD-class instructions from the E stage, runs multiplies and divides as multi-cycle operations with a down-counter, and owns the HI/LO registers. It also raises a stall request that the hazard logic ORs into the D-stage stall, so no MD-class instruction leaves D while the unit is busy or starting.

## Interface

Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu; legal range ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `E_md_op`  in  4  E-stage MD opcode:
  - 0 none; 1 mult; 2 multu; 3 div; 4 divu; 5 mfhi; 6 mflo; 7 mthi; 8 mtlo.
  - 9–15 are treated as none.
- `E_rs_value`  in  32  forwarded rs operand.
- `E_rt_value`  in  32  forwarded rt operand.
- `D_md_use`  in  1  D-stage instruction is MD-class (op 1–8).
- `md_stall`  out  1  stall request to hazard control.
- `busy`  out  1  operation in flight.
- `E_md_read_data`  out  32  result for mfhi/mflo.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation

- **States:**
  - IDLE (`busy`=0).
  - RUN (`busy`=1, counter `cnt` nonzero).
  - `cnt` width is `$clog2(max(MULT_CYCLES,DIV_CYCLES))+1`.
- **Start.** `start` = `E_md_op` ∈ {1..4} in IDLE. On that edge:
  - Compute the result from `E_rs_value`/`E_rt_value` into `pend_hi`/`pend_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`; enter RUN.
- **Arithmetic:**
  - mult: signed 32×32→64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32→64, same split.
  - div: signed; LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
  - divu: unsigned; LO = quotient, HI = remainder.
  - Divide by zero, both signednesses: HI = rs, LO = 32'hFFFF_FFFF.
  - Signed overflow (0x8000_0000 / −1): LO = 0x8000_0000, HI = 0.
- **RUN.** `cnt` decrements each edge. On the edge where `cnt`==1:
  - `hi`←`pend_hi`, `lo`←`pend_lo`, `cnt`←0.
  - Return to IDLE.
- **Moves.** mthi/mtlo in IDLE: `hi`/`lo` ← `E_rs_value` at the edge.
- **Reads.** `E_md_read_data`:
  - `hi` when op=5.
  - `lo` when op=6.
  - 0 otherwise.
  - Combinational, reflects the current register value.
- **Stall.** `md_stall` = `D_md_use` && (`busy` || E op ∈ {1..4}). Combinational.
- **Protocol violation** (any op 1–8 arriving in RUN; prevented by `md_stall`): ignored.
  - Start ops do not restart or alter `cnt`.
  - mthi/mtlo do not write.
  - mfhi/mflo still return the stale register value.

## Timing

- **Reset.** `reset_n` low asynchronously clears:
  - `hi`, `lo`, `pend_hi`, `pend_lo`, `cnt` → 0; state → IDLE.
  - Therefore `busy`=0, `md_stall`=0 (unless E op is a start and `D_md_use`=1), `E_md_read_data`=0.
  - Reset mid-operation abandons the pending result; HI/LO read 0 afterwards.
- **Start latency.** Start op in E during cycle t:
  - `busy`=1 for cycles t+1 … t+N (N = configured cycles).
  - HI/LO update at the edge closing cycle t+N; new values visible from cycle t+N+1, when `busy`=0.
- **Stall coverage.** `md_stall` is asserted in cycle t (from the start term) and in t+1 … t+N (from `busy`).
  - A dependent mfhi in D reaches E no earlier than t+N+1 and reads the fresh value.
- **Back-to-back.** A start in E in the first IDLE cycle (t+N+1) begins a new operation immediately; no dead cycle is required.
- **mthi/mtlo then mfhi/mflo.** The write lands at the edge; the next instruction in E reads the new value. No stall.
- **Simultaneity.** The completion edge and an E op in the same cycle cannot coexist, because `busy`=1 blocks D. If forced by a bench, completion wins and the E op is ignored.

## Test plan

- **mult:** rs=0xFFFF_FFFE (−2), rt=3, op=1.
  - `busy` high exactly 5 cycles.
  - Then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
  - `md_stall`=1 throughout while `D_md_use`=1.
- **divu then div:**
  - divu rs=100, rt=7 → after 10 busy cycles lo=14, hi=2.
  - Immediately div rs=−7, rt=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
  - No idle gap between the two operations.
- **Divide by zero and overflow:**
  - div rs=5, rt=0 → hi=5, lo=0xFFFF_FFFF.
  - div rs=0x8000_0000, rt=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- **Moves and reads:**
  - mthi rs=0x1234_5678, next cycle op=5 → `E_md_read_data`=0x1234_5678, `md_stall`=0.
  - mtlo rs=0xA5A5_A5A5 then op=6 → 0xA5A5_A5A5.
- **Violation and reset:**
  - Start mult; in cycle 2 of RUN drive op=3 and op=7 → `cnt` and `hi` unaffected, the mult result still lands at cycle 5.
  - Start div; drop `reset_n` in cycle 4 → `busy`, `hi`, `lo` = 0 immediately (asynchronous), no later write occurs.
